// File: rtl/imem_if.sv
// Instruction memory read bus between the fetch unit and memory.
// master: fetch unit (req/addr out); slave: memory (rdata/ack out).
interface imem_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, one outstanding imem read, 2-entry FIFO.
// Ports: clk, rst (async, active-high), stall, flush, redirect_pc,
//        imem (imem_if.master), if_instruction, if_pc, if_valid.
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  logic [7:0] redirect_pc,
    imem_if.master     imem,
    output logic [7:0] if_instruction,
    output logic [7:0] if_pc,
    output logic       if_valid
);

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } entry_t;

    // slot0 is always the FIFO head; slot1 is only live when count==2.
    entry_t     slot0;
    entry_t     slot1;
    entry_t     new_e;
    logic [7:0] fetch_pc;
    logic [1:0] count;
    logic       push;
    logic       pop;

    always_comb begin
        imem.imem_req  = !rst && (count < 2'd2) && !flush;
        imem.imem_addr = fetch_pc;
        push           = imem.imem_req && imem.imem_ack;
        if_valid       = (count != 2'd0);
        pop            = if_valid && !stall && !flush;
        new_e          = '{instr: imem.imem_rdata, pc: fetch_pc};
        if_instruction = if_valid ? slot0.instr : 8'h00;
        if_pc          = if_valid ? slot0.pc    : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            count    <= 2'd0;
            slot0    <= '0;
            slot1    <= '0;
        end else if (flush) begin
            // Redirect wins over everything; any ack this cycle is dropped.
            fetch_pc <= redirect_pc;
            count    <= 2'd0;
        end else begin
            if (push)
                fetch_pc <= fetch_pc + 8'd1;
            unique case ({push, pop})
                // Push needs count<2 and pop needs count>0, so count==1.
                2'b11: slot0 <= new_e;
                2'b10: begin
                    if (count == 2'd0)
                        slot0 <= new_e;
                    else
                        slot1 <= new_e;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table plus
// hand-written reset, stall-fill and PC wrap sequences.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       flush;
    logic [7:0] rpc;
    logic       ack;

    logic [7:0] if_instr0, if_pc0;
    logic       if_valid0;
    logic [7:0] if_instr1, if_pc1;
    logic       if_valid1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_if bus0 ();
    imem_if bus1 ();

    // Memory model: data is address + 0x10.
    assign bus0.imem_ack   = ack;
    assign bus0.imem_rdata = bus0.imem_addr + 8'h10;
    assign bus1.imem_ack   = 1'b1;
    assign bus1.imem_rdata = bus1.imem_addr + 8'h10;

    instr_fetch_unit dut0 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_pc    (rpc),
        .imem           (bus0.master),
        .if_instruction (if_instr0),
        .if_pc          (if_pc0),
        .if_valid       (if_valid0)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .flush          (1'b0),
        .redirect_pc    (8'h00),
        .imem           (bus1.master),
        .if_instruction (if_instr1),
        .if_pc          (if_pc1),
        .if_valid       (if_valid1)
    );

    typedef struct {
        logic       stall;
        logic       flush;
        logic [7:0] rpc;
        logic       ack;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_instr;
        logic [7:0] e_pc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        logic s, logic f, logic [7:0] r, logic a,
        logic q, logic [7:0] ad, logic v,
        logic [7:0] ins, logic [7:0] p
    );
        vec_t t;
        t.stall = s;  t.flush = f;  t.rpc = r;  t.ack = a;
        t.e_req = q;  t.e_addr = ad; t.e_valid = v;
        t.e_instr = ins; t.e_pc = p;
        return t;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic chk0(string tag, logic q, logic [7:0] ad,
                        logic v, logic [7:0] ins, logic [7:0] p);
        chk({tag, ".req"},   {7'd0, bus0.imem_req}, {7'd0, q});
        chk({tag, ".addr"},  bus0.imem_addr, ad);
        chk({tag, ".valid"}, {7'd0, if_valid0}, {7'd0, v});
        chk({tag, ".instr"}, if_instr0, ins);
        chk({tag, ".pc"},    if_pc0, p);
    endtask

    task automatic chk1(string tag, logic q, logic [7:0] ad,
                        logic v, logic [7:0] ins, logic [7:0] p);
        chk({tag, ".req"},   {7'd0, bus1.imem_req}, {7'd0, q});
        chk({tag, ".addr"},  bus1.imem_addr, ad);
        chk({tag, ".valid"}, {7'd0, if_valid1}, {7'd0, v});
        chk({tag, ".instr"}, if_instr1, ins);
        chk({tag, ".pc"},    if_pc1, p);
    endtask

    initial begin
        //           st fl rpc    ak rq addr   v  instr  pc
        vecs[0]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 8'h00, 8'h00);
        vecs[1]  = mk(0, 0, 8'h00, 1, 1, 8'h01, 1, 8'h10, 8'h00);
        vecs[2]  = mk(0, 0, 8'h00, 1, 1, 8'h02, 1, 8'h11, 8'h01);
        vecs[3]  = mk(0, 0, 8'h00, 1, 1, 8'h03, 1, 8'h12, 8'h02);
        vecs[4]  = mk(1, 0, 8'h00, 1, 1, 8'h04, 1, 8'h13, 8'h03);
        vecs[5]  = mk(1, 0, 8'h00, 1, 0, 8'h05, 1, 8'h13, 8'h03);
        vecs[6]  = mk(0, 0, 8'h00, 1, 0, 8'h05, 1, 8'h13, 8'h03);
        vecs[7]  = mk(0, 0, 8'h00, 1, 1, 8'h05, 1, 8'h14, 8'h04);
        vecs[8]  = mk(0, 0, 8'h00, 0, 1, 8'h06, 1, 8'h15, 8'h05);
        vecs[9]  = mk(0, 0, 8'h00, 0, 1, 8'h06, 0, 8'h00, 8'h00);
        vecs[10] = mk(0, 0, 8'h00, 0, 1, 8'h06, 0, 8'h00, 8'h00);
        vecs[11] = mk(0, 0, 8'h00, 1, 1, 8'h06, 0, 8'h00, 8'h00);
        vecs[12] = mk(1, 0, 8'h00, 1, 1, 8'h07, 1, 8'h16, 8'h06);
        vecs[13] = mk(1, 1, 8'h40, 1, 0, 8'h08, 1, 8'h16, 8'h06);
        vecs[14] = mk(0, 0, 8'h00, 0, 1, 8'h40, 0, 8'h00, 8'h00);
        vecs[15] = mk(0, 0, 8'h00, 1, 1, 8'h40, 0, 8'h00, 8'h00);
        vecs[16] = mk(0, 0, 8'h00, 0, 1, 8'h41, 1, 8'h50, 8'h40);
        vecs[17] = mk(0, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00, 8'h00);

        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        rpc   = 8'h00;
        ack   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk0("rst", 0, 8'h00, 0, 8'h00, 8'h00);
        chk({"rst1", ".req"}, {7'd0, bus1.imem_req}, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i != 0) @(negedge clk);
            stall = vecs[i].stall;
            flush = vecs[i].flush;
            rpc   = vecs[i].rpc;
            ack   = vecs[i].ack;
            #1;
            chk0($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
        end

        // Reset in the middle of a pending access to 0x41.
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        ack   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk0("midrst", 0, 8'h00, 0, 8'h00, 8'h00);

        // Stall-fill from reset with ack always high.
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b1;
        ack   = 1'b1;
        #1;
        chk0("fill0", 1, 8'h00, 0, 8'h00, 8'h00);
        @(negedge clk); #1;
        chk0("fill1", 1, 8'h01, 1, 8'h10, 8'h00);
        @(negedge clk); #1;
        chk0("fill2", 0, 8'h02, 1, 8'h10, 8'h00);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk0("fill3", 0, 8'h02, 1, 8'h10, 8'h00);
        @(negedge clk); #1;
        chk0("fill4", 1, 8'h02, 1, 8'h11, 8'h01);

        // PC wrap on the RESET_PC=FE instance.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("wrap0", 1, 8'hFE, 0, 8'h00, 8'h00);
        @(negedge clk); #1;
        chk1("wrap1", 1, 8'hFF, 1, 8'h0E, 8'hFE);
        @(negedge clk); #1;
        chk1("wrap2", 1, 8'h00, 1, 8'h0F, 8'hFF);
        @(negedge clk); #1;
        chk1("wrap3", 1, 8'h01, 1, 8'h10, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port stall, input, 1, high means the decode stage does not consume this cycle.
REQ-005 The block SHALL have port flush, input, 1, high means redirect fetch and discard buffered or pending instructions.
REQ-006 The block SHALL have port redirect_pc, input, 8, new fetch address, sampled when flush=1.
REQ-007 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 8, instruction memory read address.
REQ-009 The block SHALL have port imem_rdata, input, 8, read data, valid when imem_ack=1.
REQ-010 The block SHALL have port imem_ack, input, 1, read complete, meaningful only while imem_req=1.
REQ-011 The block SHALL have port if_instruction, output, 8, instruction presented to decode; 8'h00 (NOP) when none is available.
REQ-012 The block SHALL have port if_pc, output, 8, address of if_instruction; 8'h00 when none is available.
REQ-013 The block SHALL have port if_valid, output, 1, high when if_instruction/if_pc hold a real fetched instruction.

Function
REQ-014 The block SHALL hold an 8-bit fetch PC, a 2-entry FIFO of {instruction, pc} and a 2-bit occupancy count (0..2).
REQ-015 The block SHALL drive imem_req=1 iff count<2 and flush=0; imem_addr SHALL equal the fetch PC at all times.
REQ-016 The block SHALL allow at most one outstanding access; imem_req and imem_addr SHALL stay stable until imem_ack is sampled high, unless flush occurs.
REQ-017 On an edge with imem_req=1 and imem_ack=1, the block SHALL push {imem_rdata, fetch PC} into the FIFO tail and increment the PC by 1 mod 256 (8'hFF -> 8'h00).
REQ-018 Zero wait states (ack in the request cycle) SHALL sustain one fetch per cycle; each wait state adds one cycle.
REQ-019 The block SHALL drive if_valid=(count!=0) and if_instruction/if_pc from the FIFO head; when count=0 they SHALL be 8'h00/8'h00.
REQ-020 The FIFO head SHALL be popped on an edge where if_valid=1, stall=0 and flush=0.
REQ-021 When a push and a pop occur on the same edge, count SHALL be unchanged and FIFO order preserved.
REQ-022 When count=2, the block SHALL deassert imem_req; when a pop frees a slot, imem_req SHALL reassert on the following cycle.
REQ-023 flush SHALL take priority over stall, push and pop: at that edge, count<=0, PC<=redirect_pc, and any imem_ack/imem_rdata in that cycle SHALL be discarded.
REQ-024 In the cycle after flush, the block SHALL present if_valid=0 and outputs 8'h00, and SHALL assert imem_req with imem_addr=redirect_pc.
REQ-025 When stall=1 and count=0, the block SHALL keep fetching and SHALL NOT change outputs except by pushing.
REQ-026 Latency from the imem_ack edge to the instruction at if_instruction SHALL be 0 cycles after that edge, with no combinational bypass from imem_rdata to if_instruction.

Reset
REQ-027 While rst=1, the block SHALL force PC=RESET_PC, count=0, FIFO contents=0, imem_req=0, if_valid=0, if_instruction=8'h00 and if_pc=8'h00.
REQ-028 rst asserted mid-access SHALL abandon the access; after release, the first request SHALL be to RESET_PC.

Verification
REQ-029 Reset scenario: rst pulse, then release -> imem_req=1, imem_addr=8'h00, if_valid=0, if_instruction=8'h00.
REQ-030 Streaming scenario: ack every cycle, rdata=addr+8'h10, stall=0 -> if_pc 00,01,02,... and if_instruction 10,11,12,... one per cycle.
REQ-031 Stall-fill scenario: stall=1 from reset with ack always high -> FIFO holds pc 00 and 01, imem_req=0 with imem_addr=8'h02; release stall -> outputs 00, then 01, and the request for 02 resumes.
REQ-032 Wait-state scenario: ack 3 cycles after req -> imem_addr stable and imem_req high for all 3 cycles, then one push.
REQ-033 Flush scenario: FIFO full, request pending with ack high in the flush cycle, flush=1, redirect_pc=8'h40 -> next cycle if_valid=0, imem_addr=8'h40, discarded data never appears.
REQ-034 Wrap scenario: RESET_PC=8'hFE, stream 3 fetches -> if_pc FE, FF, 00.
